// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the MIPS instruction fetch stage.
// Contents: datapath width constants, reset/NOP defaults, the IF/ID
// pipeline record and a word-alignment helper for redirect targets.
package instruction_fetch_stage_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  // Increment applied to the PC for sequential fetch.
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  // sll $0,$0,0 -- harmless bubble for decode.
  localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam logic [PC_W-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic [PC_W-1:0]    pcplus4;
    logic               valid;
  } ifid_t;

  // Force a byte address onto a word boundary.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return addr & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_ifid_register.sv
// ifid_register: IF/ID pipeline register with hold (stall) and squash (flush).
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   stall  in   hold current contents
//   flush  in   load a bubble (wins over stall)
//   d      in   fetched record to capture
//   q      out  registered record to decode
// Parameter NOP_WORD is the instruction placed in the register as a bubble.
module ifid_register
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  stall,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  localparam ifid_t BUBBLE = '{instruction: NOP_WORD, pcplus4: '0, valid: 1'b0};

  // Reset/flush squash, stall holds, otherwise capture.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q <= BUBBLE;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: MIPS fetch stage. Owns the PC, presents it to the
// 128-word combinational instruction memory and captures the returned word
// in the IF/ID register.
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   Stall                      hold PC and IF/ID
//   Redirect, RedirectTarget   control transfer, target word-aligned here
//   Flush                      squash IF/ID to a bubble
//   InstrAddress               current PC to instruction memory
//   InstrIn                    instruction memory read data
//   IFID_Instruction/PCPlus4/Valid   IF/ID register contents
//   FetchCount, StallCount     performance counters (FETCH_PERF_CNT_EN only)
// Optional feature macro: FETCH_PERF_CNT_EN.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC = RESET_PC_DEFAULT,
  parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Redirect,
  input  logic [PC_W-1:0]    RedirectTarget,
  input  logic               Flush,
  output logic [PC_W-1:0]    InstrAddress,
  input  logic [INSTR_W-1:0] InstrIn,
  output logic [INSTR_W-1:0] IFID_Instruction,
  output logic [PC_W-1:0]    IFID_PCPlus4,
  output logic               IFID_Valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        FetchCount,
  output logic [31:0]        StallCount
`endif
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] redirect_pc;
  ifid_t           ifid_d;
  ifid_t           ifid_q;

  // Sequential successor wraps naturally at 2^32.
  assign pc_plus4    = pc + PC_STEP;
  assign redirect_pc = word_align(RedirectTarget);

  // Redirect beats Stall so a control transfer is never lost.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc <= RESET_PC;
    end else if (Redirect) begin
      pc <= redirect_pc;
    end else if (!Stall) begin
      pc <= pc_plus4;
    end
  end

  assign InstrAddress = pc;

  assign ifid_d = '{instruction: InstrIn, pcplus4: pc_plus4, valid: 1'b1};

  ifid_register #(
    .NOP_WORD (NOP_WORD)
  ) u_ifid (
    .clk   (Clk),
    .reset (Reset),
    .stall (Stall),
    .flush (Flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign IFID_Instruction = ifid_q.instruction;
  assign IFID_PCPlus4     = ifid_q.pcplus4;
  assign IFID_Valid       = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  // Count edges that load a real instruction, and stalled edges.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (!Flush && !Stall) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (Stall) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end

  assign FetchCount = fetch_count;
  assign StallCount = stall_count;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Testbench for instruction_fetch_stage: directed scenarios followed by
// randomized control traffic, compared against a behavioural fetch model.
module tb_instruction_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Redirect, Flush;
  logic [31:0] RedirectTarget;
  logic [31:0] InstrAddress, InstrIn;
  logic [31:0] IFID_Instruction, IFID_PCPlus4;
  logic        IFID_Valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount, StallCount;
`endif

  logic [31:0] imem [128];

  // Instruction memory: word index from address bits [8:2], aliasing above.
  assign InstrIn = imem[InstrAddress[8:2]];

  always #5 Clk = ~Clk;

  instruction_fetch_stage #(
    .RESET_PC (RST_PC),
    .NOP_WORD (NOP)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Stall            (Stall),
    .Redirect         (Redirect),
    .RedirectTarget   (RedirectTarget),
    .Flush            (Flush),
    .InstrAddress     (InstrAddress),
    .InstrIn          (InstrIn),
    .IFID_Instruction (IFID_Instruction),
    .IFID_PCPlus4     (IFID_PCPlus4),
    .IFID_Valid       (IFID_Valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCount       (FetchCount),
    .StallCount       (StallCount)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state of the fetch stage.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [31:0] m_fetches, m_stalls;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_all();
    check("pc", InstrAddress, m_pc);
    check("ifid_instr", IFID_Instruction, m_instr);
    check("ifid_pc4", IFID_PCPlus4, m_pc4);
    check("ifid_valid", 32'(IFID_Valid), 32'(m_valid));
`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt", FetchCount, m_fetches);
    check("stall_cnt", StallCount, m_stalls);
`endif
  endtask

  // Apply one cycle of control inputs, advance the model, compare.
  task automatic step(input logic rst, input logic stl, input logic rdr,
                      input logic [31:0] tgt, input logic fls);
    logic [31:0] fetched;
    logic [6:0]  widx;
    Reset = rst; Stall = stl; Redirect = rdr; RedirectTarget = tgt; Flush = fls;
    widx    = m_pc[8:2];
    fetched = imem[widx];
    @(posedge Clk);
    #1;
    if (rst) begin
      m_pc = RST_PC; m_instr = NOP; m_pc4 = 0; m_valid = 0;
      m_fetches = 0; m_stalls = 0;
    end else begin
      if (fls) begin
        m_instr = NOP; m_pc4 = 0; m_valid = 0;
      end else if (!stl) begin
        m_instr = fetched; m_pc4 = m_pc + 4; m_valid = 1;
        m_fetches = m_fetches + 1;
      end
      if (stl) m_stalls = m_stalls + 1;
      if (rdr)       m_pc = {tgt[31:2], 2'b00};
      else if (!stl) m_pc = m_pc + 4;
    end
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) imem[i] = $urandom;
    imem[0] = 32'h3404_0000;
    imem[1] = 32'h3405_0100;
    m_pc = 'x; m_instr = 'x; m_pc4 = 'x; m_valid = 1'bx;
    m_fetches = 'x; m_stalls = 'x;
    Reset = 1; Stall = 0; Redirect = 0; RedirectTarget = 0; Flush = 0;
    #1;

    // Reset two cycles, then sequential fetch.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_pc", InstrAddress, 32'h0);
    check("rst_valid", 32'(IFID_Valid), 32'h0);
    run(1);
    check("seq_pc4", InstrAddress, 32'h4);
    check("seq_instr0", IFID_Instruction, 32'h3404_0000);
    check("seq_pc4_0", IFID_PCPlus4, 32'h4);
    run(1);
    check("seq_instr1", IFID_Instruction, 32'h3405_0100);
    check("seq_pc4_1", IFID_PCPlus4, 32'h8);
    run(3);
    check("at_14", InstrAddress, 32'h14);

    // Three stall cycles at PC 0x14.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("stall_pc", InstrAddress, 32'h14);
    check("stall_ifid_pc4", IFID_PCPlus4, 32'h14);
    run(1);
    check("resume_pc", InstrAddress, 32'h18);

    // Redirect with flush from PC 0x68.
    step(1'b0, 1'b0, 1'b1, 32'h68, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h28, 1'b1);
    check("flush_pc", InstrAddress, 32'h28);
    check("flush_valid", 32'(IFID_Valid), 32'h0);
    check("flush_instr", IFID_Instruction, 32'h0);

    // Redirect together with stall.
    run(1);
    step(1'b0, 1'b1, 1'b1, 32'h30, 1'b0);
    check("rdr_stall_pc", InstrAddress, 32'h30);
    check("rdr_stall_ifid", IFID_PCPlus4, 32'h2C);

    // Misaligned target and PC wrap.
    step(1'b0, 1'b0, 1'b1, 32'h0000_002B, 1'b0);
    check("align_pc", InstrAddress, 32'h28);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run(1);
    check("wrap_pc", InstrAddress, 32'h0);
    check("wrap_ifid_pc4", IFID_PCPlus4, 32'h0);

    // Flush and stall together: bubble wins, PC holds.
    run(2);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check("fl_st_pc", InstrAddress, 32'h8);
    check("fl_st_valid", 32'(IFID_Valid), 32'h0);

    // Reset during a stall at PC 0x40.
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h80, 1'b1);
    check("mid_rst_pc", InstrAddress, 32'h0);
    check("mid_rst_valid", 32'(IFID_Valid), 32'h0);

    // Randomized control traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 25),
           ($urandom_range(99) < 12), $urandom, ($urandom_range(99) < 10));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage of the MIPS datapath: owns the program counter, drives the word address into the 128-word instruction memory, and captures the returned instruction in the IF/ID pipeline register for decode. Handles sequential advance, branch/jump redirection from decode/execute, hazard stalls and squash flushes. The instruction memory read is combinational and completes in the same cycle as the PC value.

## Interface
Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset
- NOP_WORD, 32'h00000000, instruction word inserted into IF/ID on flush or reset (sll $0,$0,0)

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Stall  in  1  hold PC and IF/ID contents (load-use hazard)
- Redirect  in  1  take RedirectTarget as next PC (taken branch, j, jal, jr)
- RedirectTarget  in  32  next-PC value when Redirect=1
- Flush  in  1  load NOP_WORD into IF/ID, clear IFID_Valid
- InstrAddress  out  32  current PC, to instruction memory Address
- InstrIn  in  32  instruction returned by instruction memory for InstrAddress
- IFID_Instruction  out  32  registered instruction to decode
- IFID_PCPlus4  out  32  registered PC+4 of that instruction
- IFID_Valid  out  1  IF/ID holds a real fetched instruction
- FetchCount  out  32  present only with FETCH_PERF_CNT_EN
- StallCount  out  32  present only with FETCH_PERF_CNT_EN

## Operation
- PC register 32 bits; InstrAddress = PC combinationally. PCPlus4 = PC + 4, modulo 2^32 (wraps 32'hFFFFFFFC -> 0).
- Next-PC priority per rising edge: Reset -> RESET_PC; else Redirect -> {RedirectTarget[31:2], 2'b00}; else Stall -> hold; else PCPlus4.
- Redirect overrides Stall for the PC (control transfer never lost).
- IF/ID update priority: Reset or Flush -> {NOP_WORD, 32'h0, Valid=0}; else Stall -> hold all three; else {InstrIn, PCPlus4, Valid=1}.
- Redirect does not itself flush IF/ID; the hazard unit asserts Flush alongside when squashing is required.
- No address range check: PC beyond 508 aliases in memory (bits [8:2] only).
- Reset values: PC=RESET_PC, IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0, counters=0.

## Timing
- Instruction for PC N appears in IF/ID one cycle after PC=N, i.e. fetch latency 1 cycle.
- Redirect asserted in cycle t: InstrAddress=target in cycle t+1.
- Stall asserted in cycle t: PC and IF/ID at t+1 equal values at t; any number of consecutive stall cycles allowed.
- Flush+Stall same cycle: IF/ID gets NOP (flush wins), PC holds unless Redirect.
- Reset mid-operation: all state returns to reset values at the next edge regardless of Stall/Redirect/Flush; first fetch after deassert is RESET_PC.

## Configuration
- FETCH_PERF_CNT_EN defined: FetchCount increments on each edge where IF/ID loads with Valid=1; StallCount increments on each edge where Stall=1 and Reset=0; both wrap at 2^32, cleared by Reset.
- Not defined: counter registers and ports absent; no other behaviour change.

## Structure
- Shared package: NOP_WORD default, RESET_PC default, PC width constant (32), instruction width constant, IF/ID record typedef (instruction, pcplus4, valid).
- One sub-module: ifid_register (stall/flush-capable pipeline register); PC logic and next-PC mux in the top.

## Test plan
- Reset 2 cycles, release, no stalls -> InstrAddress 0,4,8,12; IFID_Instruction one cycle behind, e.g. 32'h34040000 then 32'h34050100 with IFID_PCPlus4 4, 8.
- Stall high 3 cycles at PC=32'h14 -> InstrAddress stays 32'h14, IF/ID unchanged, StallCount +3 (macro on), resumes at 32'h18.
- Redirect=1, RedirectTarget=32'h28 at PC=32'h68 with Flush=1 -> next InstrAddress 32'h28, IFID_Valid=0, IFID_Instruction=0.
- Redirect and Stall same cycle, target 32'h30 -> PC becomes 32'h30; IF/ID held.
- RedirectTarget=32'h0000002B -> InstrAddress 32'h28; PC 32'hFFFFFFFC advancing -> 32'h0.
- Reset asserted during stall at PC=32'h40 -> next edge PC=0, IFID_Valid=0, counters 0.
